// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: hazard inputs from ID/EX/MEM, and the
// write/flush strobes and status it returns to the pipeline.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             exmem_mem_read;
  logic             exmem_mem_write;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             mem_timeout;
  logic [7:0]       wait_count;
  logic [CNT_W-1:0] stall_count;

  // Pipeline datapath side
  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt, exmem_branch, exmem_zero,
           exmem_mem_read, exmem_mem_write, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_flush, exmem_flush, memwb_flush, mem_timeout, wait_count,
           stall_count
  );

  // Hazard controller side
  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt, exmem_branch, exmem_zero,
           exmem_mem_read, exmem_mem_write, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_flush, exmem_flush, memwb_flush, mem_timeout, wait_count,
           stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Handles load-use stalls, MEM-resolved branch flushes and multi-cycle
// data-memory waits with a timeout lock.
// Optional macro STALL_STATS_EN: when defined, stall_count counts cycles
// with pc_write=0 (saturating); otherwise it is tied to zero.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, LOCK} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_count_q, wait_count_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic mem_access, branch_taken, load_use, frozen;
  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign mem_access   = hz.exmem_mem_read | hz.exmem_mem_write;
  assign branch_taken = hz.exmem_branch & hz.exmem_zero;
  assign load_use     = hz.idex_mem_read & (hz.idex_rt != 5'd0) &
                        ((hz.idex_rt == hz.id_rs) | (hz.idex_rt == hz.id_rt));
  // Memory freeze: a new unready access in RUN, or still waiting in MEM_WAIT
  assign frozen = ~hz.mem_ready &
                  (((state_q == RUN) & mem_access) | (state_q == MEM_WAIT));

  // Strobes: reset > lock > memory freeze > branch flush > load-use stall
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (reset) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
    end else if (state_q == LOCK || frozen) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      memwb_flush = 1'b1;
    end else if (branch_taken) begin
      // Dependent instruction in ID is squashed, so load-use is moot here
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next state: track memory wait length and trip into LOCK on timeout
  always_comb begin
    state_d       = state_q;
    wait_count_d  = wait_count_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_access && !hz.mem_ready) begin
          state_d      = MEM_WAIT;
          wait_count_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d      = RUN;
          wait_count_d = 8'd0;
        end else if (wait_count_q == 8'(TIMEOUT_CYCLES)) begin
          state_d       = LOCK;
          mem_timeout_d = 1'b1;
        end else begin
          wait_count_d = wait_count_q + 8'd1;
        end
      end
      default: ; // LOCK holds until reset
    endcase
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      wait_count_q  <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_count_q  <= wait_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Saturating count of cycles where the PC is held
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && stall_count_q != '1)
      stall_count_d = stall_count_q + 1'b1;
  end

  // Stall statistics register
  always_ff @(posedge clock) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign hz.stall_count = stall_count_q;
`else
  assign hz.stall_count = '0;
`endif

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.idex_write  = idex_write;
  assign hz.exmem_write = exmem_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_flush = memwb_flush;
  assign hz.mem_timeout = mem_timeout_q;
  assign hz.wait_count  = wait_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline. It drives write-enable and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
- load-use data hazards;
- taken branches resolved in MEM;
- multi-cycle data-memory accesses.
It also supervises memory waits with a timeout and an error lock.

Parameters:
TIMEOUT_CYCLES, 15, max consecutive MEM_WAIT cycles before error lock (1..255)
CNT_W, 16, width of stall statistics counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
idex_mem_read  in  1  instruction in EX is a load
idex_rt  in  5  destination rt of load in EX
exmem_branch  in  1  branch flag latched in EX/MEM
exmem_zero  in  1  ALU zero latched in EX/MEM
exmem_mem_read  in  1  memRead latched in EX/MEM
exmem_mem_write  in  1  memWrite latched in EX/MEM
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_write  out  1  ID/EX load enable
exmem_write  out  1  EX/MEM load enable
ifid_flush  out  1  IF/ID loads zeros (bubble)
idex_flush  out  1  ID/EX loads zeros (control bits cleared)
exmem_flush  out  1  EX/MEM loads zeros
memwb_flush  out  1  MEM/WB loads bubble
mem_timeout  out  1  sticky error flag
wait_count  out  8  current MEM_WAIT cycle count
stall_count  out  CNT_W  cycles with pc_write=0

Behaviour:
- Interface: one clock, port clock. Reset port reset is synchronous and active-high.
- Reset cycle: state RUN, wait_count=0, stall_count=0, mem_timeout=0.
  - While reset=1: all *_write=0 and all *_flush=1, so every pipeline register is cleared.
- State register FSM with states RUN, MEM_WAIT and LOCK. Strobes are combinational from state and inputs; zero-cycle latency to the pipeline registers.
- Definitions:
  - mem_access = exmem_mem_read | exmem_mem_write
  - branch_taken = exmem_branch & exmem_zero
  - load_use = idex_mem_read & (idex_rt != 0) & ((idex_rt == id_rs) | (idex_rt == id_rt))
- Default strobes: all *_write=1, all *_flush=0.
- Priority, highest first: LOCK, memory wait, branch flush, load-use stall.
- RUN, mem_access & !mem_ready:
  - Freeze: pc/ifid/idex/exmem_write=0 and memwb_flush=1.
  - Next state MEM_WAIT, wait_count<=1.
- RUN, mem_access & mem_ready: no stall; normal advance.
- MEM_WAIT:
  - Same freeze as in RUN while !mem_ready; wait_count increments.
  - On mem_ready=1: freeze released that same cycle, next state RUN, wait_count<=0.
  - If wait_count==TIMEOUT_CYCLES & !mem_ready: next state LOCK, mem_timeout<=1.
- Branch (not frozen, branch_taken=1):
  - ifid_flush, idex_flush, exmem_flush=1 for exactly one cycle; pc_write=1 (target mux external).
  - Load-use is ignored that cycle, since the dependent instruction is squashed.
- Load-use (not frozen, no branch):
  - pc_write=0, ifid_write=0, idex_flush=1 for one cycle.
  - The load then advances to MEM, clearing the condition.
- A branch with memory access in the same EX/MEM entry cannot occur. If it does, the memory wait completes first; the branch flush is then applied on release.
- LOCK: all *_write=0, memwb_flush=1. Exits only via reset; mem_timeout stays 1 until reset.
- Reset asserted mid-MEM_WAIT or in LOCK returns to RUN on the next edge, with counters cleared.
- stall_count increments each non-reset cycle with pc_write=0 and saturates at all-ones.

Optional Feature:
STALL_STATS_EN
- Defined: stall_count implemented as above.
- Undefined: no counter register; stall_count tied to 0. All other behaviour identical.

Test Plan:
1. Load-use: idex_mem_read=1, idex_rt=5, id_rs=5 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle all writes=1.
2. Load to $0: idex_rt=0, id_rs=0 -> no stall, pc_write=1.
3. Branch taken: exmem_branch=1, exmem_zero=1 with load_use also true -> ifid/idex/exmem_flush=1 for 1 cycle, pc_write=1; exmem_zero=0 -> no flush.
4. Memory wait: exmem_mem_read=1, mem_ready low 3 cycles then high -> freeze for 3 cycles, memwb_flush=1 during them, wait_count 1,2,3, release on the ready cycle, stall_count=3 (STALL_STATS_EN).
5. Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> LOCK after wait_count=4, mem_timeout=1 persists, later mem_ready=1 ignored; reset -> RUN, mem_timeout=0, stall_count=0.
6. Reset during MEM_WAIT: reset=1 at wait_count=2 -> all flushes=1 during reset; after release state RUN, wait_count=0.
